// File: rtl/seq_ctrl.sv
// Instruction sequencer: owns pc/ir/acc, masters the ROM/RAM block through a
// registered address/write-data/strobe interface, and runs a
// FETCH -> EXEC (-> WRITE -> HOLD) loop until HALT.
module seq_ctrl #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] mem_rdata,
    output logic [7:0]  mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_wr,
    output logic [7:0]  pc,
    output logic [15:0] ir,
    output logic [15:0] acc,
    output logic        carry,
    output logic [2:0]  state,
    output logic        halted,
    output logic        err
);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StFetch = 3'd1,
        StExec  = 3'd2,
        StWrite = 3'd3,
        StHold  = 3'd4,
        StHalt  = 3'd5
    } state_e;

    localparam logic [3:0] OpNop  = 4'h0;
    localparam logic [3:0] OpLda  = 4'h1;
    localparam logic [3:0] OpSta  = 4'h2;
    localparam logic [3:0] OpAdd  = 4'h3;
    localparam logic [3:0] OpSub  = 4'h4;
    localparam logic [3:0] OpJmp  = 4'h5;
    localparam logic [3:0] OpJz   = 4'h6;
    localparam logic [3:0] OpLdi  = 4'h7;
    localparam logic [3:0] OpHalt = 4'hF;

    // First RAM address; anything below is ROM and must never be written.
    localparam logic [7:0] RamBase = 8'h40;

    state_e      state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic [15:0] acc_q, acc_d;
    logic        carry_q, carry_d;
    logic [7:0]  addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        wr_q, wr_d;
    logic        err_q, err_d;

    logic [3:0]  opcode;
    logic [7:0]  operand;
    logic [16:0] sum;
    logic [16:0] diff;

    assign opcode  = ir_q[15:12];
    assign operand = ir_q[7:0];
    // Bit 16 of the 17-bit result is the carry for ADD and the borrow for SUB.
    assign sum     = {1'b0, acc_q} + {1'b0, mem_rdata};
    assign diff    = {1'b0, acc_q} - {1'b0, mem_rdata};

    // Next-state and datapath updates; everything holds unless a state says otherwise.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        err_d   = err_q;

        unique case (state_q)
            StIdle: begin
                addr_d = pc_q;
                if (start) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                ir_d    = mem_rdata;
                pc_d    = pc_q + 8'd1;
                addr_d  = mem_rdata[7:0];
                state_d = StExec;
            end
            StExec: begin
                // Default exit: fetch the next sequential instruction.
                state_d = StFetch;
                addr_d  = pc_q;
                case (opcode)
                    OpNop: begin
                    end
                    OpLda: acc_d = mem_rdata;
                    OpSta: begin
                        if (operand < RamBase) begin
                            err_d = 1'b1;
                        end else begin
                            state_d = StWrite;
                            addr_d  = operand;
                            wdata_d = acc_q;
                            wr_d    = 1'b1;
                        end
                    end
                    OpAdd: {carry_d, acc_d} = sum;
                    OpSub: {carry_d, acc_d} = diff;
                    OpJmp: begin
                        pc_d   = operand;
                        addr_d = operand;
                    end
                    OpJz: begin
                        if (acc_q == 16'h0000) begin
                            pc_d   = operand;
                            addr_d = operand;
                        end
                    end
                    OpLdi: acc_d = {8'h00, operand};
                    OpHalt: begin
                        state_d = StHalt;
                        addr_d  = addr_q;
                    end
                    default: begin
                        err_d   = 1'b1;
                        state_d = StHalt;
                        addr_d  = addr_q;
                    end
                endcase
            end
            StWrite: begin
                // Strobe lasts exactly one cycle; address and data stay put through HOLD.
                wr_d    = 1'b0;
                state_d = StHold;
            end
            StHold: begin
                addr_d  = pc_q;
                state_d = StFetch;
            end
            StHalt: begin
            end
            default: state_d = StIdle;
        endcase
    end

    // State register with synchronous reset taking priority over every transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            ir_q    <= 16'h0000;
            acc_q   <= 16'h0000;
            carry_q <= 1'b0;
            addr_q  <= RESET_PC;
            wdata_q <= 16'h0000;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wr    = wr_q;
    assign pc        = pc_q;
    assign ir        = ir_q;
    assign acc       = acc_q;
    assign carry     = carry_q;
    assign state     = state_q;
    assign halted    = (state_q == StHalt);
    assign err       = err_q;

endmodule
